tour_cmd_sched: RTL and testbench

Command scheduler between the UART command path and the command processor in KnightsTour. Passes remote commands straight through to the command processor. On a tour-start command it launches the tour solver and waits for its result. It then replays the solved 24-move tour as a sequence of vertical and horizontal move commands, issuing one command at a time, and generates the per-command response bytes.

---
 rtl/tour_cmd_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_tour_cmd_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sched.sv
// Command scheduler between the UART command path and the command processor:
// passes remote commands through and replays a solved knight's tour as move legs.
// Optional abort of a running tour is enabled with `define TOUR_ABORT_EN.
module tour_cmd_sched #(
    parameter int         NUM_MOVES = 24,
    parameter logic [3:0] OP_TOUR   = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        start_tour,
    input  logic        tour_done,
    output logic [4:0]  mv_indx,
    input  logic [7:0]  move,
    output logic [15:0] cmd_out,
    output logic        cmd_vld,
    input  logic        cmd_done,
    output logic [7:0]  resp,
    output logic        send_resp,
    output logic        tour_active
);

    localparam int         CNT_W    = $clog2(NUM_MOVES);
    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);
    localparam logic [7:0] HDG_N    = 8'h00;
    localparam logic [7:0] HDG_W    = 8'h3F;
    localparam logic [7:0] HDG_S    = 8'h7F;
    localparam logic [7:0] HDG_E    = 8'hBF;
    localparam logic [3:0] OP_MOVE  = 4'h2;
    localparam logic [3:0] OP_FANF  = 4'h3;
    localparam logic [7:0] RESP_ACK = 8'h5A;
    localparam logic [7:0] RESP_FIN = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PASS    = 3'd1,
        WAIT_TL = 3'd2,
        VERT    = 3'd3,
        WAIT_V  = 3'd4,
        HORZ    = 3'd5,
        WAIT_H  = 3'd6
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] cmd_out_r, cmd_out_s;
    logic        cmd_vld_r, cmd_vld_s;
    logic        start_r, start_s;
    logic [4:0]  mv_indx_r, mv_indx_s;
    logic [7:0]  resp_r, resp_s;
    logic        send_r, send_s;
    logic        active_r, active_s;
    logic        abort_s;
    logic        last_s;

    // Non-one-hot moves fall into the default arm and decode as bit0.
    function automatic logic [15:0] vert_leg(input logic [7:0] m);
        case (m)
            8'h02:   vert_leg = {OP_MOVE, HDG_N, 4'd2};
            8'h04:   vert_leg = {OP_MOVE, HDG_S, 4'd1};
            8'h08:   vert_leg = {OP_MOVE, HDG_N, 4'd1};
            8'h10:   vert_leg = {OP_MOVE, HDG_S, 4'd2};
            8'h20:   vert_leg = {OP_MOVE, HDG_S, 4'd2};
            8'h40:   vert_leg = {OP_MOVE, HDG_N, 4'd1};
            8'h80:   vert_leg = {OP_MOVE, HDG_S, 4'd1};
            default: vert_leg = {OP_MOVE, HDG_N, 4'd2};
        endcase
    endfunction

    function automatic logic [15:0] horz_leg(input logic [7:0] m);
        case (m)
            8'h02:   horz_leg = {OP_FANF, HDG_W, 4'd1};
            8'h04:   horz_leg = {OP_FANF, HDG_W, 4'd2};
            8'h08:   horz_leg = {OP_FANF, HDG_W, 4'd2};
            8'h10:   horz_leg = {OP_FANF, HDG_W, 4'd1};
            8'h20:   horz_leg = {OP_FANF, HDG_E, 4'd1};
            8'h40:   horz_leg = {OP_FANF, HDG_E, 4'd2};
            8'h80:   horz_leg = {OP_FANF, HDG_E, 4'd2};
            default: horz_leg = {OP_FANF, HDG_E, 4'd1};
        endcase
    endfunction

    assign last_s = (mv_indx_r[CNT_W-1:0] == LAST_IDX[CNT_W-1:0]);

`ifdef TOUR_ABORT_EN
    logic abort_r;

    // Abort request latched while a leg is in flight; dropped whenever the FSM returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_r <= 1'b0;
        end else if (state_s == IDLE) begin
            abort_r <= 1'b0;
        end else if ((state_r == WAIT_V || state_r == WAIT_H) && cmd_rdy && (cmd[15:12] == 4'hF)) begin
            abort_r <= 1'b1;
        end else begin
            abort_r <= abort_r;
        end
    end

    assign abort_s = abort_r;
`else
    assign abort_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (cmd_rdy) state_s = (cmd[15:12] == OP_TOUR) ? WAIT_TL : PASS;
                     else         state_s = IDLE;
            PASS:    if (cmd_done) state_s = IDLE;  else state_s = PASS;
            WAIT_TL: if (tour_done) state_s = VERT; else state_s = WAIT_TL;
            VERT:    state_s = WAIT_V;
            WAIT_V:  if (cmd_done) state_s = abort_s ? IDLE : HORZ;
                     else          state_s = WAIT_V;
            HORZ:    state_s = WAIT_H;
            WAIT_H:  if (cmd_done) state_s = (last_s || abort_s) ? IDLE : VERT;
                     else          state_s = WAIT_H;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        cmd_out_s = cmd_out_r;
        cmd_vld_s = 1'b0;
        start_s   = 1'b0;
        mv_indx_s = mv_indx_r;
        resp_s    = resp_r;
        send_s    = 1'b0;
        active_s  = active_r;
        case (state_r)
            IDLE: begin
                if (cmd_rdy && (cmd[15:12] == OP_TOUR)) begin
                    start_s   = 1'b1;
                    active_s  = 1'b1;
                    mv_indx_s = 5'd0;
                end else if (cmd_rdy) begin
                    cmd_out_s = cmd;
                    cmd_vld_s = 1'b1;
                end else begin
                    cmd_vld_s = 1'b0;
                end
            end
            PASS: begin
                if (cmd_done) begin
                    resp_s = RESP_FIN;
                    send_s = 1'b1;
                end else begin
                    send_s = 1'b0;
                end
            end
            VERT: begin
                cmd_out_s = vert_leg(move);
                cmd_vld_s = 1'b1;
            end
            WAIT_V: begin
                if (cmd_done && abort_s) begin
                    resp_s   = RESP_FIN;
                    send_s   = 1'b1;
                    active_s = 1'b0;
                end else if (cmd_done) begin
                    resp_s = RESP_ACK;
                    send_s = 1'b1;
                end else begin
                    send_s = 1'b0;
                end
            end
            HORZ: begin
                cmd_out_s = horz_leg(move);
                cmd_vld_s = 1'b1;
            end
            WAIT_H: begin
                if (cmd_done && (last_s || abort_s)) begin
                    resp_s   = RESP_FIN;
                    send_s   = 1'b1;
                    active_s = 1'b0;
                end else if (cmd_done) begin
                    resp_s    = RESP_ACK;
                    send_s    = 1'b1;
                    mv_indx_s = mv_indx_r + 5'd1;
                end else begin
                    send_s = 1'b0;
                end
            end
            default: begin
                cmd_vld_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_out_r <= 16'h0000;
            cmd_vld_r <= 1'b0;
            start_r   <= 1'b0;
            mv_indx_r <= 5'd0;
            resp_r    <= 8'h00;
            send_r    <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            cmd_out_r <= cmd_out_s;
            cmd_vld_r <= cmd_vld_s;
            start_r   <= start_s;
            mv_indx_r <= mv_indx_s;
            resp_r    <= resp_s;
            send_r    <= send_s;
            active_r  <= active_s;
        end
    end

    assign cmd_out     = cmd_out_r;
    assign cmd_vld     = cmd_vld_r;
    assign start_tour  = start_r;
    assign mv_indx     = mv_indx_r;
    assign resp        = resp_r;
    assign send_resp   = send_r;
    assign tour_active = active_r;

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Directed bench for tour_cmd_sched: pass-through, tour replay, drops, resets,
// and (with TOUR_ABORT_EN) the abort path.
module tb_tour_cmd_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        cmd_rdy = 1'b0;
    logic        start_tour;
    logic        tour_done = 1'b0;
    logic [4:0]  mv_indx;
    logic [7:0]  move;
    logic [15:0] cmd_out;
    logic        cmd_vld;
    logic        cmd_done = 1'b0;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tour_active;
    logic        bad_mv = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int vld_cnt = 0;
    int ack_cnt = 0;
    int fin_cnt = 0;

    tour_cmd_sched dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .start_tour(start_tour), .tour_done(tour_done), .mv_indx(mv_indx),
        .move(move), .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_done(cmd_done),
        .resp(resp), .send_resp(send_resp), .tour_active(tour_active)
    );

    always #5 clk = ~clk;

    // Solver model: move cycles through bits 0..7 by index, or a two-hot pattern.
    assign move = bad_mv ? 8'h03 : (8'h01 << mv_indx[2:0]);

    always @(posedge clk) begin
        if (cmd_vld) vld_cnt <= vld_cnt + 1;
        if (send_resp && resp == 8'h5A) ack_cnt <= ack_cnt + 1;
        if (send_resp && resp == 8'hA5) fin_cnt <= fin_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference decode from the (dy,dx) table; non-one-hot decodes as bit0.
    function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horiz);
        int dy_t[8];
        int dx_t[8];
        int k;
        int v;
        dy_t = '{2, 2, -1, 1, -2, -2, 1, -1};
        dx_t = '{1, -1, -2, -2, -1, 1, 2, 2};
        k = 0;
        if ($countones(m) == 1)
            for (int b = 0; b < 8; b++) if (m[b]) k = b;
        if (!horiz) begin
            v = (dy_t[k] < 0) ? -dy_t[k] : dy_t[k];
            return {4'h2, (dy_t[k] > 0) ? 8'h00 : 8'h7F, 4'(v)};
        end else begin
            v = (dx_t[k] < 0) ? -dx_t[k] : dx_t[k];
            return {4'h3, (dx_t[k] > 0) ? 8'hBF : 8'h3F, 4'(v)};
        end
    endfunction

    task automatic begin_tour();
        cmd = 16'h4000; cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        chk("start_pulse", start_tour, 1);
        chk("start_active", tour_active, 1);
        chk("start_idx", mv_indx, 0);
        chk("start_no_vld", cmd_vld, 0);
        tick();
        chk("start_one_cycle", start_tour, 0);
        tour_done = 1'b1;
        tick();
        tour_done = 1'b0;
        chk("tl_no_vld_yet", cmd_vld, 0);
        tick();
        chk("tl_vld_2cyc", cmd_vld, 1);
    endtask

    // Entered with the vertical cmd_vld of move i visible.
    task automatic run_move(input int i, input logic [7:0] m, input bit drop, input bit stop_h);
        chk("vert_cmd", cmd_out, exp_leg(m, 1'b0));
        chk("vert_idx", mv_indx, i);
        if (drop) begin
            cmd = 16'h2001; cmd_rdy = 1'b1;
            tick();
            cmd_rdy = 1'b0;
            chk("drop_no_vld", cmd_vld, 0);
            chk("drop_no_resp", send_resp, 0);
        end
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("vert_resp_pulse", send_resp, 1);
        chk("vert_resp", resp, 8'h5A);
        tick();
        chk("horz_vld", cmd_vld, 1);
        chk("horz_cmd", cmd_out, exp_leg(m, 1'b1));
        if (!stop_h) begin
            cmd_done = 1'b1;
            tick();
            cmd_done = 1'b0;
            chk("horz_resp_pulse", send_resp, 1);
            if (i == 23) begin
                chk("final_resp", resp, 8'hA5);
                chk("final_inactive", tour_active, 0);
                chk("final_idx", mv_indx, 23);
            end else begin
                chk("horz_resp", resp, 8'h5A);
                chk("idx_incr", mv_indx, i + 1);
                chk("next_vert_gap", cmd_vld, 0);
                tick();
                chk("next_vert_vld", cmd_vld, 1);
            end
        end
    endtask

    initial begin
        int v0, a0, f0;
        // Reset
        tick(); tick();
        chk("rst_cmd_out", cmd_out, 16'h0000);
        chk("rst_cmd_vld", cmd_vld, 0);
        chk("rst_start", start_tour, 0);
        chk("rst_idx", mv_indx, 0);
        chk("rst_resp", resp, 8'h00);
        chk("rst_send", send_resp, 0);
        chk("rst_active", tour_active, 0);
        rst = 1'b0;
        tick();

        // Pass-through
        cmd = 16'h2001; cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        chk("pt_vld", cmd_vld, 1);
        chk("pt_cmd", cmd_out, 16'h2001);
        chk("pt_active", tour_active, 0);
        tick();
        chk("pt_vld_pulse", cmd_vld, 0);
        chk("pt_hold", cmd_out, 16'h2001);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("pt_send", send_resp, 1);
        chk("pt_resp", resp, 8'hA5);
        tick();
        chk("pt_send_pulse", send_resp, 0);

        // Simultaneous cmd_rdy and cmd_done in PASS: response wins, command dropped
        cmd = 16'h3005; cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        chk("pt2_cmd", cmd_out, 16'h3005);
        cmd = 16'h2007; cmd_rdy = 1'b1; cmd_done = 1'b1;
        tick();
        cmd_rdy = 1'b0; cmd_done = 1'b0;
        chk("sim_send", send_resp, 1);
        chk("sim_no_vld", cmd_vld, 0);
        tick();
        chk("sim_dropped_vld", cmd_vld, 0);
        chk("sim_dropped_cmd", cmd_out, 16'h3005);

        // Full tour, bits 0..7 cycled, with a drop during WAIT_V of move 2
        tick();
        v0 = vld_cnt; a0 = ack_cnt; f0 = fin_cnt;
        begin_tour();
        chk("first_vert_hand", cmd_out, 16'h2002);
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin
                cmd_done = 1'b1; tick(); cmd_done = 1'b0;
                chk("first_vert_resp", resp, 8'h5A);
                tick();
                chk("first_horz_hand", cmd_out, 16'h3BF1);
                cmd_done = 1'b1; tick(); cmd_done = 1'b0;
                chk("first_horz_resp", resp, 8'h5A);
                tick();
                chk("move1_vert_hand", cmd_out, 16'h203F + 16'h0000 - 16'h003F + 16'h0002);
            end else begin
                run_move(i, 8'h01 << (i % 8), i == 2, 1'b0);
            end
        end
        tick();
        chk("tour_vld_count", vld_cnt - v0, 48);
        chk("tour_ack_count", ack_cnt - a0, 47);
        chk("tour_fin_count", fin_cnt - f0, 1);
        chk("tour_idle_active", tour_active, 0);

        // Non-one-hot moves decode as bit0; reset in WAIT_H at index 10
        bad_mv = 1'b1;
        begin_tour();
        for (int i = 0; i <= 10; i++) run_move(i, 8'h03, 1'b0, i == 10);
        chk("bad_horz_hand", cmd_out, 16'h3BF1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_active", tour_active, 0);
        chk("mid_rst_idx", mv_indx, 0);
        chk("mid_rst_send", send_resp, 0);
        chk("mid_rst_cmd", cmd_out, 16'h0000);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("idle_done_ignored", send_resp, 0);
        chk("idle_done_no_vld", cmd_vld, 0);
        bad_mv = 1'b0;

`ifdef TOUR_ABORT_EN
        begin_tour();
        cmd = 16'hF000; cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        chk("abort_no_vld", cmd_vld, 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("abort_send", send_resp, 1);
        chk("abort_resp", resp, 8'hA5);
        chk("abort_inactive", tour_active, 0);
        tick();
        chk("abort_no_horz", cmd_vld, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
